// File: rtl/inst_cache.sv
// Direct-mapped read-only instruction cache with a 4-word line refilled over a single-outstanding word interface.
// Optional ICACHE_CRITICAL_WORD_EN: refill starts at the requested word and answers fetch as soon as it arrives.
module inst_cache #(
   parameter int INDEX_BITS = 6,
   parameter int LINE_WORDS = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        rdy,
   input  logic        pc_send_enable,
   input  logic [31:0] pc_to_ic,
   output logic        inst_get_ready,
   output logic [31:0] inst_from_ic,
   output logic        mem_req_valid,
   output logic [31:0] mem_req_addr,
   input  logic        mem_resp_valid,
   input  logic [31:0] mem_resp_data
);

   localparam int TAG_W = 28 - INDEX_BITS;
   localparam int LINES = 2 ** INDEX_BITS;

   typedef enum logic [1:0] {IDLE, REFILL, DONE} state_t;

   state_t state_q, state_d;
   logic [1:0]  cnt_q, cnt_d;
   logic [1:0]  crit_q, crit_d;
   logic [27:0] base_q, base_d;
   logic        answered_q, answered_d;
   logic        ready_d;
   logic [31:0] inst_d;
   logic        req_d;
   logic [31:0] addr_d;
   logic        wr_en, valid_set, valid_clr;

   logic [31:0]      data_mem [0:LINES*LINE_WORDS-1];
   logic [TAG_W-1:0] tag_mem  [0:LINES-1];
   logic [LINES-1:0] valid_q;

   logic [INDEX_BITS-1:0] pc_idx, fill_idx;
   logic [TAG_W-1:0]      pc_tag;
   logic [1:0]            pc_word, fill_word;
   logic                  hit, line_match, rsp;
   logic                  unused_pc_bits;

   assign pc_idx         = pc_to_ic[3+INDEX_BITS:4];
   assign pc_tag         = pc_to_ic[31:4+INDEX_BITS];
   assign pc_word        = pc_to_ic[3:2];
   assign fill_idx       = base_q[INDEX_BITS-1:0];
   assign fill_word      = crit_q + cnt_q;
   assign hit            = valid_q[pc_idx] && (tag_mem[pc_idx] == pc_tag);
   assign line_match     = (pc_to_ic[31:4] == base_q);
   assign rsp            = mem_req_valid && mem_resp_valid;
   assign unused_pc_bits = ^pc_to_ic[1:0];

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      crit_d     = crit_q;
      base_d     = base_q;
      answered_d = answered_q;
      ready_d    = 1'b0;
      inst_d     = inst_from_ic;
      req_d      = mem_req_valid;
      addr_d     = mem_req_addr;
      wr_en      = 1'b0;
      valid_set  = 1'b0;
      valid_clr  = 1'b0;
      case (state_q)
         IDLE: begin
            // The cycle after a pulse fetch is still dropping enable, so it is ignored.
            if (pc_send_enable && !inst_get_ready) begin
               if (hit) begin
                  ready_d = 1'b1;
                  inst_d  = data_mem[{pc_idx, pc_word}];
               end else begin
                  base_d     = pc_to_ic[31:4];
`ifdef ICACHE_CRITICAL_WORD_EN
                  crit_d     = pc_word;
`else
                  crit_d     = 2'd0;
`endif
                  cnt_d      = 2'd0;
                  answered_d = 1'b0;
                  req_d      = 1'b1;
                  addr_d     = {pc_to_ic[31:4], crit_d, 2'b00};
                  valid_clr  = 1'b1;
                  state_d    = REFILL;
               end
            end
         end
         REFILL: begin
            if (rsp) begin
               wr_en = 1'b1;
               req_d = 1'b0;
`ifdef ICACHE_CRITICAL_WORD_EN
               if (cnt_q == 2'd0 && pc_send_enable && line_match) begin
                  ready_d    = 1'b1;
                  inst_d     = mem_resp_data;
                  answered_d = 1'b1;
               end
`endif
               if (cnt_q == 2'd3) begin
                  valid_set = 1'b1;
                  state_d   = DONE;
               end else begin
                  cnt_d = cnt_q + 2'd1;
               end
            end else if (!mem_req_valid) begin
               req_d  = 1'b1;
               addr_d = {base_q, fill_word, 2'b00};
            end
         end
         DONE: begin
            // An aborted or already answered fetch gets no pulse here.
            if (pc_send_enable && line_match && !answered_q) begin
               ready_d = 1'b1;
               inst_d  = data_mem[{fill_idx, pc_word}];
            end
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q        <= IDLE;
         cnt_q          <= 2'd0;
         answered_q     <= 1'b0;
         valid_q        <= '0;
         inst_get_ready <= 1'b0;
         inst_from_ic   <= 32'd0;
         mem_req_valid  <= 1'b0;
         mem_req_addr   <= 32'd0;
      end else if (!rdy) begin
         inst_get_ready <= 1'b0;
      end else begin
         state_q        <= state_d;
         cnt_q          <= cnt_d;
         answered_q     <= answered_d;
         inst_get_ready <= ready_d;
         inst_from_ic   <= inst_d;
         mem_req_valid  <= req_d;
         mem_req_addr   <= addr_d;
         if (valid_clr) valid_q[pc_idx]   <= 1'b0;
         if (valid_set) valid_q[fill_idx] <= 1'b1;
      end
   end

   // Line storage and the latched refill address carry no reset; valid bits gate their use.
   always_ff @(posedge clk) begin
      if (rdy) begin
         base_q <= base_d;
         crit_q <= crit_d;
         if (wr_en)     data_mem[{fill_idx, fill_word}] <= mem_resp_data;
         if (valid_set) tag_mem[fill_idx] <= base_q[27:INDEX_BITS];
      end
   end

endmodule
